// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One quotient bit per cycle; out = {remainder, quotient}.
module seq_divider #(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [width:0]     rem_q, rem_d;
  logic [width-1:0]   quo_q, quo_d;
  logic [width-1:0]   div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*width-1:0] out_q, out_d;
  logic               err_q, err_d;

  logic [width+1:0]   shift_w;
  logic [width+1:0]   diff_w;
  logic               ge_w;
  logic [width:0]     rem_n;
  logic [width-1:0]   quo_n;
  logic               b_zero;
  logic               last;

  assign b_zero = (b == '0);
  assign last   = (cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    out  = out_q;
    err  = err_q;
  end

  // One restoring step: shift in next dividend bit, trial-subtract.
  // The partial remainder is always below the divisor, so the top
  // bit of the widened difference is a reliable borrow indicator.
  always_comb begin
    shift_w = {rem_q, quo_q[width-1]};
    diff_w  = shift_w - {2'b00, div_q};
    ge_w    = ~diff_w[width+1];
    rem_n   = ge_w ? diff_w[width:0] : shift_w[width:0];
    quo_n   = {quo_q[width-2:0], ge_w};
  end

  // Datapath next-state.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    cnt_d = cnt_q;
    out_d = out_q;
    err_d = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && b_zero) begin
          out_d = {a, {width{1'b1}}};
          err_d = 1'b1;
        end else if (start) begin
          rem_d = '0;
          quo_d = a;
          div_d = b;
          cnt_d = CW'(width);
          err_d = 1'b0;
        end
      end
      S_RUN: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          out_d = {rem_n[width-1:0], quo_n};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider
// against a timeline-based arithmetic model.
module tb_seq_divider;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] out;
  logic           busy;
  logic           done;
  logic           err;

  int errors = 0;
  int checks = 0;

  seq_divider #(.width(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .out  (out),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: tracks only when the accepted op finishes and what
  // its arithmetic result is.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_active = 0;
  bit          m_nz = 0;
  int          m_done_at = 0;
  logic [11:0] m_out = '0;
  logic [11:0] m_pend = '0;
  bit          m_err = 0;
  bit          m_busy_x = 0;
  bit          m_done_x = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0;
      m_out    = '0;
      m_err    = 0;
      chk_en   = 1;
    end else begin
      if (!m_active && start) begin
        m_active = 1;
        m_nz     = (b != 0);
        if (b == 0) begin
          m_done_at = cyc;
          m_out     = {a, 6'h3F};
          m_err     = 1;
        end else begin
          m_done_at = cyc + W;
          m_pend    = {W'(a % b), W'(a / b)};
          m_err     = 0;
        end
      end else if (m_active && cyc >= m_done_at + 1) begin
        m_active = 0;
      end
      if (m_active && m_nz && cyc == m_done_at) m_out = m_pend;
    end
    m_done_x = m_active && (cyc == m_done_at);
    m_busy_x = m_active && !m_done_x;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 12'(busy), 12'(m_busy_x));
      chk("done", 12'(done), 12'(m_done_x));
      chk("err",  12'(err),  12'(m_err));
      chk("out",  out,       m_out);
    end
  end

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit lit, input logic [11:0] xo,
                       input bit xe);
    int n;
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    if (ib != 0) chk("launch_busy", 12'(busy), 12'd1);
    else         chk("launch_done", 12'(done), 12'd1);
    n = 0;
    while (!done && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 12'(done), 12'd1);
    end else if (lit) begin
      chk("out_lit",   out,   xo);
      chk("model_lit", m_out, xo);
      chk("err_lit",   12'(err), 12'(xe));
    end
    start = ($urandom_range(0, 1) == 1);
    a     = W'($urandom);
    b     = W'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out",  out,       12'h000);
    chk("rst_busy", 12'(busy), 12'd0);
    chk("rst_err",  12'(err),  12'd0);

    do_op(6'd45, 6'd7, 1, 12'h0C6, 0);

    do_op(6'd63, 6'd1,  1, 12'h03F, 0);
    do_op(6'd63, 6'd63, 1, 12'h001, 0);
    do_op(6'd5,  6'd9,  1, 12'h140, 0);

    do_op(6'd37, 6'd0, 1, 12'h97F, 1);
    do_op(6'd20, 6'd4, 1, 12'h005, 0);

    start = 1'b1; a = 6'd45; b = 6'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 6'd1; b = 6'd1;
    @(negedge clk);
    start = 1'b0; a = 6'd9; b = 6'd2;
    n = 0;
    while (!done && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done", 12'(done), 12'd1);
    chk("ign_out",  out,       12'h0C6);
    repeat (4) @(negedge clk);

    start = 1'b1; a = 6'd45; b = 6'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", 12'(busy), 12'd0);
    chk("mrst_done", 12'(done), 12'd0);
    chk("mrst_out",  out,       12'h000);
    chk("mrst_err",  12'(err),  12'd0);
    repeat (W + 2) @(negedge clk);
    do_op(6'd45, 6'd7, 1, 12'h0C6, 0);

    rst_n = 1'b0; start = 1'b1; a = 6'd45; b = 6'd7;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("rs_busy", 12'(busy), 12'd0);
    @(negedge clk);
    chk("rs_busy2", 12'(busy), 12'd0);
    chk("rs_done",  12'(done), 12'd0);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 63));
      do_op(ra, rb, 0, 12'h000, 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
